vga_timing_gen: RTL and testbench

//  Parametrised VGA/raster timing generator; the successor to the fixed 640x480 generator.

---
 rtl/vga_timing_gen_if.sv | 51 +++++
 rtl/vga_timing_gen.sv | 154 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Bundle between the raster timing generator and the logic that consumes
//   its timing (pixel pipeline, frame buffer read logic).
//
//   Signals
//     pix_stb      pixel enable into the generator (one pixel per high clk)
//     hsync        horizontal sync, polarity chosen by the generator
//     vsync        vertical sync, polarity chosen by the generator
//     blanking     high outside the visible area
//     active       high inside the visible area (always ~blanking)
//     line_start   1-clk pulse when pixel (0, any line) is presented
//     frame_start  1-clk pulse when pixel (0,0) is presented
//     animate      1-clk pulse at the last pixel of the last visible line
//     screenend    1-clk pulse at the last pixel of the frame
//     x, y         coordinates of the presented pixel (CW bits)
//     frame_cnt    frame counter (FRAME_W bits)
//
//   Modports
//     master  the timing generator
//     slave   the timing consumer (also supplies pix_stb)
interface vga_timing_gen_if #(
    parameter int CW      = 10,
    parameter int FRAME_W = 8
);
    logic               pix_stb;
    logic               hsync;
    logic               vsync;
    logic               blanking;
    logic               active;
    logic               line_start;
    logic               frame_start;
    logic               animate;
    logic               screenend;
    logic [CW-1:0]      x;
    logic [CW-1:0]      y;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        input  pix_stb,
        output hsync, vsync, blanking, active,
        output line_start, frame_start, animate, screenend,
        output x, y, frame_cnt
    );

    modport slave (
        output pix_stb,
        input  hsync, vsync, blanking, active,
        input  line_start, frame_start, animate, screenend,
        input  x, y, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator. A horizontal counter walks each
//   line (active, front porch, sync, back porch) and a vertical counter walks
//   the lines of a frame. Every output is registered from the decode of the
//   same (h,v) pair, so sync, blanking, coordinates and pulses always describe
//   one pixel and never skew against each other.
//
//   Ports
//     clk    system clock, all logic on its rising edge
//     reset  synchronous, active-low reset
//     vif    vga_timing_gen_if master modport: pix_stb in, timing outputs out
//
//   CW must be wide enough to hold max(H_TOTAL, V_TOTAL) - 1.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 10,
    parameter int   FRAME_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    vga_timing_gen_if.master      vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode boundaries pre-sized to the counter width so every compare is
    // between equal-width unsigned values.
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_ANIM   = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0]      h_q, h_d;
    logic [CW-1:0]      v_q, v_d;
    logic [CW-1:0]      x_q, x_d;
    logic [CW-1:0]      y_q, y_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               visible_q, visible_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               animate_q, animate_d;
    logic               screenend_q, screenend_d;

    logic               h_wrap;
    logic               v_wrap;

    // Counter advance and one-pixel-late output decode. Levels hold between
    // strobes; pulses default to zero so they last exactly one clk even when
    // the strobe is sparse.
    always_comb begin
        h_wrap        = (h_q == H_LAST);
        v_wrap        = (v_q == V_LAST);

        h_d           = h_q;
        v_d           = v_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_cnt_d   = frame_cnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        visible_d     = visible_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        animate_d     = 1'b0;
        screenend_d   = 1'b0;

        if (vif.pix_stb) begin
            h_d = h_wrap ? '0 : h_q + CW'(1);
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + CW'(1);
            end

            x_d       = h_q;
            y_d       = v_q;
            visible_d = (h_q < H_ACT) && (v_q < V_ACT);
            hsync_d   = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
            vsync_d   = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;

            line_start_d  = (h_q == '0);
            frame_start_d = (h_q == '0) && (v_q == '0);
            animate_d     = h_wrap && (v_q == V_ANIM);
            screenend_d   = h_wrap && v_wrap;

            // The frame counter steps together with the screenend pixel so
            // both appear on the same output cycle.
            if (h_wrap && v_wrap) begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
        end
    end

    // State and output registers. Reset wins over the strobe and restarts the
    // raster at (0,0), discarding the frame in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_q           <= '0;
            v_q           <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_cnt_q   <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            visible_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            animate_q     <= 1'b0;
            screenend_q   <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_cnt_q   <= frame_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            visible_q     <= visible_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            animate_q     <= animate_d;
            screenend_q   <= screenend_d;
        end
    end

    // Blanking and active come from one flop so they can never disagree.
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.active      = visible_q;
    assign vif.blanking    = ~visible_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.animate     = animate_q;
    assign vif.screenend   = screenend_q;
    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Instance dut_a uses the default
//   640x480 timing and exercises line-level behaviour, sparse strobing and a
//   mid-frame reset. Instance dut_b uses a 10x10 raster with high-asserted
//   syncs and a 2-bit frame counter, which keeps frame-level behaviour
//   (vsync, animate, screenend, frame counter, aborted frame) short.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;

    int total = 0;
    int bad   = 0;

    vga_timing_gen_if #(.CW(10), .FRAME_W(8)) vif_a ();
    vga_timing_gen_if #(.CW(10), .FRAME_W(2)) vif_b ();

    vga_timing_gen dut_a (
        .clk   (clk),
        .reset (reset_a),
        .vif   (vif_a.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .HS_POL   (1'b1), .VS_POL (1'b1),
        .CW       (10), .FRAME_W (2)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .vif   (vif_b.master)
    );

    always #5 clk = ~clk;

    // Drive both instances' controls for one clk edge, then sample 1 ns later.
    task automatic applyStimulus(input logic ra, input logic sa,
                                 input logic rb, input logic sb);
        reset_a       = ra;
        vif_a.pix_stb = sa;
        reset_b       = rb;
        vif_b.pix_stb = sb;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Line-level tallies for dut_a
    int   hs_low, hs_first, act_cnt, ls_cnt, ls_last, ls_gap_err;
    int   fs_cnt, pulse_bad, xy_err, blank_err;
    // Sparse strobe tallies
    int   stab_err, width_err, k;
    logic prev_ls, prev_fs, prev_hs, prev_act;
    logic [9:0] prev_x;
    // Frame-level tallies for dut_b
    int   vs_cnt, vs_first, an_cnt, an_x, an_y, se_cnt, se_x, se_y;
    int   fs_last, fs_gap_err, act_err, fc98, fc99;
    int   fc_seq [5];

    initial begin
        $display("[TB] start");

        // ---------------- reset state ----------------
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_x",           32'(vif_a.x),           32'd0);
        checkOutput("rst_y",           32'(vif_a.y),           32'd0);
        checkOutput("rst_frame_cnt",   32'(vif_a.frame_cnt),   32'd0);
        checkOutput("rst_hsync",       32'(vif_a.hsync),       32'd1);
        checkOutput("rst_vsync",       32'(vif_a.vsync),       32'd1);
        checkOutput("rst_blanking",    32'(vif_a.blanking),    32'd1);
        checkOutput("rst_active",      32'(vif_a.active),      32'd0);
        checkOutput("rst_line_start",  32'(vif_a.line_start),  32'd0);
        checkOutput("rst_frame_start", 32'(vif_a.frame_start), 32'd0);
        checkOutput("rst_animate",     32'(vif_a.animate),     32'd0);
        checkOutput("rst_screenend",   32'(vif_a.screenend),   32'd0);
        checkOutput("rst_b_hsync",     32'(vif_b.hsync),       32'd0);
        checkOutput("rst_b_vsync",     32'(vif_b.vsync),       32'd0);
        checkOutput("rst_b_blanking",  32'(vif_b.blanking),    32'd1);

        // ---------------- dut_a full rate, three lines ----------------
        hs_low = 0; hs_first = -1; act_cnt = 0; ls_cnt = 0; ls_last = -1;
        ls_gap_err = 0; fs_cnt = 0; pulse_bad = 0; xy_err = 0; blank_err = 0;
        for (int i = 0; i < 2400; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 0) begin
                checkOutput("first_frame_start", 32'(vif_a.frame_start), 32'd1);
                checkOutput("first_line_start",  32'(vif_a.line_start),  32'd1);
                checkOutput("first_active",      32'(vif_a.active),      32'd1);
            end
            if (vif_a.x !== 10'(i % 800) || vif_a.y !== 10'(i / 800)) xy_err++;
            if (i < 800) begin
                if (vif_a.hsync === 1'b0) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = 32'(vif_a.x);
                end
                if (vif_a.active === 1'b1) act_cnt++;
            end
            if (vif_a.blanking !== ~vif_a.active) blank_err++;
            if (vif_a.line_start === 1'b1) begin
                if (ls_last >= 0 && (i - ls_last) != 800) ls_gap_err++;
                ls_last = i;
                ls_cnt++;
            end
            if (vif_a.frame_start === 1'b1) fs_cnt++;
            if (vif_a.animate !== 1'b0 || vif_a.screenend !== 1'b0) pulse_bad++;
        end
        checkOutput("a_xy_track_errors",   32'(xy_err),     32'd0);
        checkOutput("a_hsync_low_strobes", 32'(hs_low),     32'd96);
        checkOutput("a_hsync_first_x",     32'(hs_first),   32'd656);
        checkOutput("a_active_per_line",   32'(act_cnt),    32'd640);
        checkOutput("a_blank_vs_active",   32'(blank_err),  32'd0);
        checkOutput("a_line_start_count",  32'(ls_cnt),     32'd3);
        checkOutput("a_line_start_gap",    32'(ls_gap_err), 32'd0);
        checkOutput("a_frame_start_count", 32'(fs_cnt),     32'd1);
        checkOutput("a_no_frame_pulses",   32'(pulse_bad),  32'd0);

        // ---------------- dut_a strobe 1 clk in 4 ----------------
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stab_err = 0; width_err = 0; xy_err = 0; ls_cnt = 0; fs_cnt = 0; hs_low = 0;
        prev_ls = 1'b0; prev_fs = 1'b0;
        prev_hs = vif_a.hsync; prev_act = vif_a.active; prev_x = vif_a.x;
        for (int c = 0; c < 6400; c++) begin
            applyStimulus(1'b1, (c % 4) == 0, 1'b0, 1'b0);
            k = c / 4;
            if ((c % 4) == 0) begin
                if (vif_a.x !== 10'(k % 800)) xy_err++;
                if (vif_a.hsync === 1'b0) hs_low++;
            end else begin
                if (vif_a.x !== prev_x || vif_a.hsync !== prev_hs ||
                    vif_a.active !== prev_act) stab_err++;
                if (vif_a.line_start !== 1'b0 || vif_a.frame_start !== 1'b0)
                    width_err++;
            end
            if ((vif_a.line_start && prev_ls) || (vif_a.frame_start && prev_fs))
                width_err++;
            if (vif_a.line_start === 1'b1) ls_cnt++;
            if (vif_a.frame_start === 1'b1) fs_cnt++;
            prev_ls = vif_a.line_start; prev_fs = vif_a.frame_start;
            prev_hs = vif_a.hsync; prev_act = vif_a.active; prev_x = vif_a.x;
        end
        checkOutput("s4_x_per_strobe",   32'(xy_err),    32'd0);
        checkOutput("s4_level_stable",   32'(stab_err),  32'd0);
        checkOutput("s4_pulse_width",    32'(width_err), 32'd0);
        checkOutput("s4_line_start_cnt", 32'(ls_cnt),    32'd2);
        checkOutput("s4_frame_start_cnt",32'(fs_cnt),    32'd1);
        checkOutput("s4_hsync_low",      32'(hs_low),    32'd192);

        // ---------------- dut_a reset mid-line ----------------
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 1100; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("abort_a_pre_x", 32'(vif_a.x), 32'd300);
        checkOutput("abort_a_pre_y", 32'(vif_a.y), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("abort_a_rst_x",      32'(vif_a.x),      32'd0);
        checkOutput("abort_a_rst_active", 32'(vif_a.active), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("abort_a_x",           32'(vif_a.x),           32'd0);
        checkOutput("abort_a_y",           32'(vif_a.y),           32'd0);
        checkOutput("abort_a_frame_start", 32'(vif_a.frame_start), 32'd1);
        checkOutput("abort_a_line_start",  32'(vif_a.line_start),  32'd1);

        // ---------------- dut_b small raster, four frames ----------------
        hs_low = 0; hs_first = -1; vs_cnt = 0; vs_first = -1; an_cnt = 0;
        an_x = -1; an_y = -1; se_cnt = 0; se_x = -1; se_y = -1; fs_cnt = 0;
        fs_last = -1; fs_gap_err = 0; xy_err = 0; act_err = 0; fc98 = -1; fc99 = -1;
        for (int i = 0; i <= 400; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            if ((i % 100) == 0) fc_seq[i / 100] = 32'(vif_b.frame_cnt);
            if (i == 98) fc98 = 32'(vif_b.frame_cnt);
            if (i == 99) fc99 = 32'(vif_b.frame_cnt);
            if (vif_b.x !== 10'(i % 10) || vif_b.y !== 10'((i / 10) % 10)) xy_err++;
            if (vif_b.active !== ((vif_b.x < 10'd4) && (vif_b.y < 10'd4))) act_err++;
            if (i < 10 && vif_b.hsync === 1'b1) begin
                hs_low++;
                if (hs_first < 0) hs_first = 32'(vif_b.x);
            end
            if (i < 100 && vif_b.vsync === 1'b1) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = 32'(vif_b.y);
            end
            if (vif_b.animate === 1'b1) begin
                an_cnt++; an_x = 32'(vif_b.x); an_y = 32'(vif_b.y);
            end
            if (vif_b.screenend === 1'b1) begin
                se_cnt++; se_x = 32'(vif_b.x); se_y = 32'(vif_b.y);
            end
            if (vif_b.frame_start === 1'b1) begin
                if (fs_last >= 0 && (i - fs_last) != 100) fs_gap_err++;
                fs_last = i;
                fs_cnt++;
            end
        end
        checkOutput("b_frame_cnt_0",     32'(fc_seq[0]), 32'd0);
        checkOutput("b_frame_cnt_1",     32'(fc_seq[1]), 32'd1);
        checkOutput("b_frame_cnt_2",     32'(fc_seq[2]), 32'd2);
        checkOutput("b_frame_cnt_3",     32'(fc_seq[3]), 32'd3);
        checkOutput("b_frame_cnt_wrap",  32'(fc_seq[4]), 32'd0);
        checkOutput("b_frame_cnt_pre",   32'(fc98),      32'd0);
        checkOutput("b_frame_cnt_step",  32'(fc99),      32'd1);
        checkOutput("b_xy_track_errors", 32'(xy_err),    32'd0);
        checkOutput("b_active_decode",   32'(act_err),   32'd0);
        checkOutput("b_hsync_high_cnt",  32'(hs_low),    32'd2);
        checkOutput("b_hsync_first_x",   32'(hs_first),  32'd6);
        checkOutput("b_vsync_high_cnt",  32'(vs_cnt),    32'd20);
        checkOutput("b_vsync_first_y",   32'(vs_first),  32'd6);
        checkOutput("b_animate_cnt",     32'(an_cnt),    32'd4);
        checkOutput("b_animate_x",       32'(an_x),      32'd9);
        checkOutput("b_animate_y",       32'(an_y),      32'd3);
        checkOutput("b_screenend_cnt",   32'(se_cnt),    32'd4);
        checkOutput("b_screenend_x",     32'(se_x),      32'd9);
        checkOutput("b_screenend_y",     32'(se_y),      32'd9);
        checkOutput("b_frame_start_cnt", 32'(fs_cnt),    32'd5);
        checkOutput("b_frame_start_gap", 32'(fs_gap_err),32'd0);

        // ---------------- dut_b reset mid-frame ----------------
        for (int i = 0; i < 53; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("abort_b_pre_x", 32'(vif_b.x), 32'd3);
        checkOutput("abort_b_pre_y", 32'(vif_b.y), 32'd5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("abort_b_rst_frame_cnt", 32'(vif_b.frame_cnt), 32'd0);
        an_cnt = 0; an_y = -1; se_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            if (i == 0) begin
                checkOutput("abort_b_frame_start", 32'(vif_b.frame_start), 32'd1);
                checkOutput("abort_b_x",           32'(vif_b.x),           32'd0);
                checkOutput("abort_b_y",           32'(vif_b.y),           32'd0);
            end
            if (vif_b.animate === 1'b1) begin
                an_cnt++; an_y = 32'(vif_b.y);
            end
            if (vif_b.screenend === 1'b1) se_cnt++;
        end
        checkOutput("abort_b_no_screenend", 32'(se_cnt), 32'd0);
        checkOutput("abort_b_animate_cnt",  32'(an_cnt), 32'd1);
        checkOutput("abort_b_animate_y",    32'(an_y),   32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
